// File: rtl/substitution_layer_seq.sv
// -----------------------------------------------------------------------------
// substitution_layer_seq
//   Sequential Ascon substitution layer. The 320-bit state is viewed as 64
//   5-bit columns (column j = {x0[j], x1[j], x2[j], x3[j], x4[j]}, x0 = MSB).
//   COLS_PER_CYCLE columns go through the 5-bit Ascon sbox on every busy
//   clock edge, so one full layer takes 64 / COLS_PER_CYCLE edges.
//
// Parameters
//   COLS_PER_CYCLE : columns substituted per clock (1, 2, 4, 8, 16, 32, 64)
//
// Ports
//   clock_i  : clock, rising edge active
//   reset_i  : asynchronous active-high reset
//   start_i  : one-cycle request to load state_i and begin (ignored while busy)
//   state_i  : input state, state_i[w] is word xw (x0..x4)
//   state_o  : working / result state register
//   busy_o   : high while a substitution is in progress
//   done_o   : one-cycle pulse when state_o holds the finished result
// -----------------------------------------------------------------------------
module substitution_layer_seq #(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [4:0][63:0] state_i,
  output logic [4:0][63:0] state_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int N  = 64 / COLS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [CW-1:0]    step_q, step_d;
  logic [4:0][63:0] state_q, state_d;
  logic             done_q, done_d;

  logic             last_step;
  logic [5:0]       base_idx;
  logic [4:0]       col_in  [COLS_PER_CYCLE];
  logic [4:0]       col_out [COLS_PER_CYCLE];

  // Bitsliced Ascon sbox on one column; bit 4 carries x0, bit 0 carries x4.
  function automatic logic [4:0] ascon_sbox(input logic [4:0] x_in);
    logic a0, a1, a2, a3, a4;
    logic t0, t1, t2, t3, t4;
    a0 = x_in[4];
    a1 = x_in[3];
    a2 = x_in[2];
    a3 = x_in[1];
    a4 = x_in[0];
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    return {a0, a1, a2, a3, a4};
  endfunction

  assign last_step = (step_q == CW'(N - 1));

  // First column handled in the current step. For N = 1 the counter is
  // always 0, so the product collapses to column 0.
  assign base_idx = 6'(32'(step_q) * COLS_PER_CYCLE);

  // One sbox per column slot; each slot reads its column out of the state.
  genvar gi;
  generate
    for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
      logic [5:0] col_idx;
      assign col_idx     = base_idx + 6'(gi);
      assign col_in[gi]  = {state_q[0][col_idx], state_q[1][col_idx],
                            state_q[2][col_idx], state_q[3][col_idx],
                            state_q[4][col_idx]};
      assign col_out[gi] = ascon_sbox(col_in[gi]);
    end
  endgenerate

  // State register process
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      step_q  <= '0;
      state_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      step_q  <= step_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state process
  always_comb begin
    fsm_d  = fsm_q;
    step_d = step_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d  = BUSY;
          step_d = '0;
        end
      end
      BUSY: begin
        if (last_step) begin
          fsm_d  = IDLE;
          step_d = '0;
          done_d = 1'b1;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath next state: load in IDLE on start, in-place substitution of the
  // current column group while BUSY, hold otherwise.
  always_comb begin
    state_d = state_q;
    if (fsm_q == IDLE) begin
      if (start_i) begin
        state_d = state_i;
      end
    end else begin
      for (int c = 0; c < COLS_PER_CYCLE; c++) begin
        for (int w = 0; w < 5; w++) begin
          state_d[w][base_idx + 6'(c)] = col_out[c][4 - w];
        end
      end
    end
  end

  // Output process
  always_comb begin
    busy_o  = (fsm_q == BUSY);
    done_o  = done_q;
    state_o = state_q;
  end

endmodule

// File: tb/tb_substitution_layer_seq.sv
module tb_substitution_layer_seq;

  typedef logic [4:0][63:0] st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic start8 = 1'b0, start1 = 1'b0, start64 = 1'b0;
  st_t  st8_i = '0, st1_i = '0, st64_i = '0;
  st_t  st8_o, st1_o, st64_o;
  logic busy8, busy1, busy64;
  logic done8, done1, done64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  substitution_layer_seq u8 (
    .clock_i(clk), .reset_i(rst), .start_i(start8), .state_i(st8_i),
    .state_o(st8_o), .busy_o(busy8), .done_o(done8)
  );

  substitution_layer_seq #(.COLS_PER_CYCLE(1)) u1 (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .state_i(st1_i),
    .state_o(st1_o), .busy_o(busy1), .done_o(done1)
  );

  substitution_layer_seq #(.COLS_PER_CYCLE(64)) u64 (
    .clock_i(clk), .reset_i(rst), .start_i(start64), .state_i(st64_i),
    .state_o(st64_o), .busy_o(busy64), .done_o(done64)
  );

  // Ascon sbox as a lookup table.
  function automatic logic [4:0] sbox_tab(input logic [4:0] x);
    case (x)
      5'h00: return 5'h04; 5'h01: return 5'h0b; 5'h02: return 5'h1f; 5'h03: return 5'h14;
      5'h04: return 5'h1a; 5'h05: return 5'h15; 5'h06: return 5'h09; 5'h07: return 5'h02;
      5'h08: return 5'h1b; 5'h09: return 5'h05; 5'h0a: return 5'h08; 5'h0b: return 5'h12;
      5'h0c: return 5'h1d; 5'h0d: return 5'h03; 5'h0e: return 5'h06; 5'h0f: return 5'h1c;
      5'h10: return 5'h1e; 5'h11: return 5'h13; 5'h12: return 5'h07; 5'h13: return 5'h0e;
      5'h14: return 5'h00; 5'h15: return 5'h0d; 5'h16: return 5'h11; 5'h17: return 5'h18;
      5'h18: return 5'h10; 5'h19: return 5'h0c; 5'h1a: return 5'h01; 5'h1b: return 5'h19;
      5'h1c: return 5'h16; 5'h1d: return 5'h0a; 5'h1e: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  // Reference: whole substitution layer, column by column.
  function automatic st_t ref_layer(input st_t s);
    st_t r;
    logic [4:0] c, o;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      o = sbox_tab(c);
      for (int w = 0; w < 5; w++) r[w][j] = o[4 - w];
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%h", tag, obs);
    end
  endtask

  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic drive(input int inst, input logic v, input st_t s);
    case (inst)
      1:  begin start1 = v;  st1_i = s;  end
      64: begin start64 = v; st64_i = s; end
      default: begin start8 = v; st8_i = s; end
    endcase
  endtask

  function automatic logic get_done(input int inst);
    case (inst)
      1:  return done1;
      64: return done64;
      default: return done8;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      1:  return busy1;
      64: return busy64;
      default: return busy8;
    endcase
  endfunction

  function automatic st_t get_state(input int inst);
    case (inst)
      1:  return st1_o;
      64: return st64_o;
      default: return st8_o;
    endcase
  endfunction

  // One complete operation on the chosen instance; checks latency, result,
  // single-cycle done pulse and busy behaviour. Returns the observed result.
  task automatic run_op(input int inst, input st_t s, input int exp_lat,
                        input string tag, output st_t res);
    st_t exp_r;
    int  lat;
    bit  seen;
    exp_r = ref_layer(s);
    res   = '0;
    drive(inst, 1'b1, s);
    @(posedge clk); #1;
    drive(inst, 1'b0, s);
    check_val({tag, "_busy"}, 320'(get_busy(inst)), 320'(1));
    seen = 0;
    lat  = 0;
    for (int e = 1; e <= 200 && !seen; e++) begin
      @(posedge clk); #1;
      if (get_done(inst)) begin
        seen = 1;
        lat  = e;
        res  = get_state(inst);
      end
    end
    check_val({tag, "_lat"}, 320'(lat), 320'(exp_lat));
    check_val({tag, "_res"}, res, exp_r);
    check_val({tag, "_idle_at_done"}, 320'(get_busy(inst)), 320'(0));
    @(posedge clk); #1;
    check_val({tag, "_done_1cyc"}, 320'(get_done(inst)), 320'(0));
    check_val({tag, "_hold"}, get_state(inst), exp_r);
  endtask

  initial begin
    st_t res, e, a, b, junk;
    int  dcount, dedge;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_state", st8_o, '0);
    check_val("rst_busy", 320'(busy8), 320'(0));
    check_val("rst_done", 320'(done8), 320'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero state
    run_op(8, '0, 8, "zero", res);
    e = '0; e[2] = '1;
    check_val("zero_const", res, e);

    // All-ones state
    run_op(8, '1, 8, "ones", res);
    e = '1; e[1] = '0;
    check_val("ones_const", res, e);

    // x4 = 1, rest 0
    a = '0; a[4] = 64'h1;
    run_op(8, a, 8, "x4one", res);
    e = '0; e[1] = 64'h1; e[3] = 64'h1; e[4] = 64'h1; e[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    check_val("x4one_const", res, e);

    // Random states, default width
    for (int i = 0; i < 8; i++) begin
      run_op(8, rand_state(), 8, $sformatf("rnd8_%0d", i), res);
    end

    // Start pulses while busy are ignored; then back-to-back start on done
    a = rand_state();
    b = rand_state();
    drive(8, 1'b1, a);
    @(posedge clk); #1;
    drive(8, 1'b0, a);
    dcount = 0;
    dedge  = 0;
    for (int ed = 1; ed <= 8; ed++) begin
      if (ed == 3 || ed == 7) begin
        junk = rand_state();
        drive(8, 1'b1, junk);
      end
      @(posedge clk); #1;
      drive(8, 1'b0, st8_i);
      if (done8) begin
        dcount++;
        dedge = ed;
      end
    end
    check_val("ign_done_cnt", 320'(dcount), 320'(1));
    check_val("ign_done_edge", 320'(dedge), 320'(8));
    check_val("ign_res", st8_o, ref_layer(a));
    // done8 is high now: issue the next start in this cycle
    drive(8, 1'b1, b);
    @(posedge clk); #1;
    drive(8, 1'b0, b);
    check_val("b2b_busy", 320'(busy8), 320'(1));
    dedge = 0;
    for (int ed = 1; ed <= 20 && dedge == 0; ed++) begin
      @(posedge clk); #1;
      if (done8) dedge = ed;
    end
    check_val("b2b_lat", 320'(dedge), 320'(8));
    check_val("b2b_res", st8_o, ref_layer(b));
    @(posedge clk); #1;

    // Reset in the middle of an operation
    a = rand_state();
    drive(8, 1'b1, a);
    @(posedge clk); #1;
    drive(8, 1'b0, a);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("midrst_state", st8_o, '0);
    check_val("midrst_busy", 320'(busy8), 320'(0));
    check_val("midrst_done", 320'(done8), 320'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    for (int ed = 0; ed < 12; ed++) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcount++;
    end
    check_val("midrst_quiet", 320'(dcount), 320'(0));
    check_val("midrst_hold0", st8_o, '0);
    run_op(8, rand_state(), 8, "postrst", res);

    // One column per cycle and whole state per cycle
    for (int i = 0; i < 3; i++) begin
      run_op(1, rand_state(), 64, $sformatf("rnd1_%0d", i), res);
    end
    for (int i = 0; i < 4; i++) begin
      run_op(64, rand_state(), 1, $sformatf("rnd64_%0d", i), res);
    end
    run_op(64, '1, 1, "ones64", res);
    e = '1; e[1] = '0;
    check_val("ones64_const", res, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/substitution_layer_seq.md
SUBSTITUTION_LAYER_SEQ -- requirements
Module: substitution_layer_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 8: the number of 5-bit columns substituted per clock; legal values are 1, 2, 4, 8, 16, 32 and 64.
REQ-002 SHALL have port clock_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: a one-cycle request to load state_i and begin the substitution layer.
REQ-005 SHALL have port state_i, input, type_state (5 x 64 bits, words x0..x4): the Ascon state after constant addition.
REQ-006 SHALL have port state_o, output, type_state (5 x 64 bits): the working/result state register.
REQ-007 SHALL have port busy_o, output, 1 bit: high while a substitution is in progress.
REQ-008 SHALL have port done_o, output, 1 bit: a one-cycle pulse when state_o holds the completed result.

Function
REQ-009 SHALL define column j (0..63) as the 5-bit vector {x0[j], x1[j], x2[j], x3[j], x4[j]}, with x0 as the MSB, mapped to sbox_i and written back from sbox_o in the same bit order.
REQ-010 SHALL apply the codebase 5-bit Ascon sbox, instantiated COLS_PER_CYCLE times, to every column exactly once per operation.
REQ-011 SHALL have N = 64 / COLS_PER_CYCLE processing steps; in step k (0..N-1) it SHALL substitute columns k*COLS_PER_CYCLE to k*COLS_PER_CYCLE + COLS_PER_CYCLE - 1 in place and leave all other bits unchanged.
REQ-012 SHALL implement a two-state FSM:
  - IDLE: busy_o = 0.
  - BUSY: busy_o = 1.
REQ-013 In IDLE, when start_i = 1 at a rising edge, SHALL load state_i into the working register, clear the step counter to 0, and move to BUSY.
REQ-014 In BUSY, SHALL perform step k at each rising edge and increment the counter; at step N-1 it SHALL return to IDLE and register done_o = 1.
REQ-015 SHALL assert done_o for exactly one cycle, N clock edges after the edge that sampled start_i (8 edges for the default parameter).
REQ-016 SHALL ignore start_i while in BUSY: no reload, and no effect on the counter or the result.
REQ-017 SHALL accept start_i in the cycle in which done_o is high (back-to-back operation); state_o then reloads from state_i at that edge.
REQ-018 SHALL hold state_o stable in IDLE until the next accepted start_i; state_o is defined as the result only while busy_o = 0 after done_o.
REQ-019 SHALL derive the step counter width as log2(N), with a minimum of 1 bit; for N = 1 the block SHALL complete in a single BUSY edge.

Reset
REQ-020 SHALL, while reset_i = 1 and regardless of the clock, force:
  - FSM = IDLE
  - counter = 0
  - state_o = all zeros
  - busy_o = 0
  - done_o = 0
REQ-021 SHALL, on reset during BUSY, abandon the operation immediately with no done_o pulse; the first start_i after reset is released SHALL begin a fresh operation.

Verification
REQ-022 SHALL be verified with all-zero state, start pulse -> after 8 edges done_o = 1 for 1 cycle; x2 = FFFFFFFFFFFFFFFF; x0 = x1 = x3 = x4 = 0.
REQ-023 SHALL be verified with all-ones state -> x0 = x2 = x3 = x4 = FFFFFFFFFFFFFFFF, x1 = 0 (column 1F -> 17).
REQ-024 SHALL be verified with x4 = 0000000000000001 and the other words 0 -> x1 = x3 = x4 = 0000000000000001; x2 = FFFFFFFFFFFFFFFE; x0 = 0.
REQ-025 SHALL be verified by pulsing start_i again at steps 3 and 7 of a busy operation -> result unchanged, a single done_o pulse at edge 8; then start_i asserted during the done_o cycle -> second result correct after 8 further edges.
REQ-026 SHALL be verified by asserting reset_i at step 4 -> state_o = 0, busy_o = 0, and no done_o until a new start_i.
REQ-027 SHALL be verified with COLS_PER_CYCLE = 1 and 64 on random states -> each result matches a per-column reference sbox model, with latencies of 64 and 1 edges respectively.
